cache_fill_ctrl: RTL and testbench

- Parametrised cache-line fill controller; the next generation of the single-outstanding miss-fill FSM.
- On a cache miss it issues pipelined word reads to multicycle memory, with up to MAX_OUTSTANDING requests in flight.
- It counts in-order responses, writes each returned word into the data array, and writes the tag array in the cycle the last word lands.
- It sits between the cache tag-match logic, the data/tag arrays and the memory arbiter. fsm_busy is the pipeline stall.

---
 rtl/cache_fill_pkg.sv | 19 +
 rtl/cache_fill_word_ctr.sv | 49 ++++
 rtl/cache_fill_ctrl.sv | 132 +++++++++++++
 tb/tb_cache_fill_ctrl.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cache_fill_pkg.sv
// Shared types and width helpers for the cache line fill controller.
package cache_fill_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    FILL = 1'b1
  } fill_state_e;

  // Width of the byte offset within one cache line.
  function automatic int unsigned off_w(input int unsigned words, input int unsigned bpw);
    return $clog2(words * bpw);
  endfunction

  // Counter width that can hold 0..words inclusive.
  function automatic int unsigned cnt_w(input int unsigned words);
    return $clog2(words) + 1;
  endfunction

endpackage

// File: rtl/cache_fill_word_ctr.sv
// Word counter with clear and increment. Maps the count to a word index within the line.
// CACHE_FILL_CRIT_WORD_FIRST_EN adds a start offset that wraps the index within the line.
module cache_fill_word_ctr
  import cache_fill_pkg::*;
#(
  parameter int unsigned WORDS_PER_BLK = 8,
  parameter int unsigned CNT_W         = cnt_w(WORDS_PER_BLK),
  parameter int unsigned IDX_W         = CNT_W - 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr_i,
  input  logic             inc_i,
`ifdef CACHE_FILL_CRIT_WORD_FIRST_EN
  input  logic [IDX_W-1:0] start_i,
`endif
  output logic [CNT_W-1:0] cnt_o,
  output logic [IDX_W-1:0] idx_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

  // Line size is a power of two, so the IDX_W-bit add wraps modulo the line.
`ifdef CACHE_FILL_CRIT_WORD_FIRST_EN
  assign idx_o = start_i + cnt_q[IDX_W-1:0];
`else
  assign idx_o = cnt_q[IDX_W-1:0];
`endif

endmodule

// File: rtl/cache_fill_ctrl.sv
// Cache line fill controller: pipelined word reads with bounded outstanding requests.
// Optional critical-word-first ordering under CACHE_FILL_CRIT_WORD_FIRST_EN.
module cache_fill_ctrl
  import cache_fill_pkg::*;
#(
  parameter int unsigned ADDR_W          = 16,
  parameter int unsigned WORD_W          = 16,
  parameter int unsigned WORDS_PER_BLK   = 8,
  parameter int unsigned BYTES_PER_WORD  = 2,
  parameter int unsigned MAX_OUTSTANDING = 4
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             miss_detected,
  input  logic [ADDR_W-1:0]                miss_address,
  output logic                             fsm_busy,
  output logic                             mem_req,
  output logic [ADDR_W-1:0]                mem_addr,
  input  logic                             mem_data_valid,
  input  logic [WORD_W-1:0]                mem_data,
  output logic                             data_we,
  output logic [$clog2(WORDS_PER_BLK)-1:0] data_word_idx,
  output logic [WORD_W-1:0]                data_wdata,
  output logic                             tag_we
);

  localparam int unsigned OFF_W  = off_w(WORDS_PER_BLK, BYTES_PER_WORD);
  localparam int unsigned CNT_W  = cnt_w(WORDS_PER_BLK);
  localparam int unsigned IDX_W  = CNT_W - 1;
  localparam int unsigned BPW_SH = $clog2(BYTES_PER_WORD);

  fill_state_e       state_q, state_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [CNT_W-1:0]  req_cnt, rsp_cnt, outstanding;
  logic [IDX_W-1:0]  req_word, rsp_word;
  logic              start_fill, req_fire, rsp_fire, last_rsp;
  logic              unused_low_addr;

`ifdef CACHE_FILL_CRIT_WORD_FIRST_EN
  logic [IDX_W-1:0] miss_off_q, miss_off_d;
`endif

  assign unused_low_addr = ^miss_address[OFF_W-1:0];

  // Handshake: mem_req is a one-cycle request with no ready (the arbiter always
  // accepts); mem_data_valid carries exactly one in-order response word per cycle.
  assign start_fill  = (state_q == IDLE) && miss_detected;
  assign outstanding = req_cnt - rsp_cnt;
  assign req_fire    = (state_q == FILL) && (req_cnt < CNT_W'(WORDS_PER_BLK))
                       && (outstanding < CNT_W'(MAX_OUTSTANDING));
  assign rsp_fire    = (state_q == FILL) && mem_data_valid && (outstanding != '0);
  assign last_rsp    = rsp_fire && (rsp_cnt == CNT_W'(WORDS_PER_BLK - 1));

  always_comb begin
    state_d = state_q;
    base_d  = base_q;
`ifdef CACHE_FILL_CRIT_WORD_FIRST_EN
    miss_off_d = miss_off_q;
`endif
    case (state_q)
      IDLE: begin
        if (miss_detected) begin
          state_d = FILL;
          base_d  = {miss_address[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
`ifdef CACHE_FILL_CRIT_WORD_FIRST_EN
          miss_off_d = miss_address[OFF_W-1:BPW_SH];
`endif
        end
      end
      FILL: begin
        if (last_rsp) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state_q <= IDLE;
      base_q  <= '0;
`ifdef CACHE_FILL_CRIT_WORD_FIRST_EN
      miss_off_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      base_q  <= base_d;
`ifdef CACHE_FILL_CRIT_WORD_FIRST_EN
      miss_off_q <= miss_off_d;
`endif
    end
  end

  cache_fill_word_ctr #(
    .WORDS_PER_BLK(WORDS_PER_BLK)
  ) u_req_ctr (
    .clk    (clk),
    .rst    (rst_n),
    .clr_i  (start_fill),
    .inc_i  (req_fire),
`ifdef CACHE_FILL_CRIT_WORD_FIRST_EN
    .start_i(miss_off_q),
`endif
    .cnt_o  (req_cnt),
    .idx_o  (req_word)
  );

  cache_fill_word_ctr #(
    .WORDS_PER_BLK(WORDS_PER_BLK)
  ) u_rsp_ctr (
    .clk    (clk),
    .rst    (rst_n),
    .clr_i  (start_fill),
    .inc_i  (rsp_fire),
`ifdef CACHE_FILL_CRIT_WORD_FIRST_EN
    .start_i(miss_off_q),
`endif
    .cnt_o  (rsp_cnt),
    .idx_o  (rsp_word)
  );

  // The idle stall follows miss_detected combinationally, but is held low during reset.
  assign fsm_busy      = (state_q == FILL) || (start_fill && !rst_n);
  assign mem_req       = req_fire;
  assign mem_addr      = req_fire ? (base_q + (ADDR_W'(req_word) << BPW_SH)) : '0;
  assign data_we       = rsp_fire;
  assign data_word_idx = rsp_fire ? rsp_word : '0;
  assign data_wdata    = rsp_fire ? mem_data : '0;
  assign tag_we        = last_rsp;

endmodule

// File: tb/tb_cache_fill_ctrl.sv
// Bench for cache_fill_ctrl: a default instance (latency 4) and a serial instance
// (MAX_OUTSTANDING=1, latency 3), each with its own memory pipe and scoreboard.
module tb_cache_fill_ctrl;

  localparam int LAT_A = 4;
  localparam int LAT_B = 3;
  localparam bit CRIT =
`ifdef CACHE_FILL_CRIT_WORD_FIRST_EN
    1'b1;
`else
    1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // ---------------- DUT A (defaults) ----------------
  logic        miss_a = 1'b0, inj_a = 1'b0;
  logic [15:0] maddr_a = '0;
  logic        a_busy, a_req, a_dv, a_we, a_tag;
  logic [15:0] a_addr, a_dd, a_wd;
  logic [2:0]  a_idx;

  cache_fill_ctrl u_dut_a (
    .clk(clk), .rst_n(rst), .miss_detected(miss_a), .miss_address(maddr_a),
    .fsm_busy(a_busy), .mem_req(a_req), .mem_addr(a_addr),
    .mem_data_valid(a_dv), .mem_data(a_dd),
    .data_we(a_we), .data_word_idx(a_idx), .data_wdata(a_wd), .tag_we(a_tag)
  );

  // ---------------- DUT B (serial) ----------------
  logic        miss_b = 1'b0;
  logic [15:0] maddr_b = '0;
  logic        b_busy, b_req, b_dv, b_we, b_tag;
  logic [15:0] b_addr, b_dd, b_wd;
  logic [2:0]  b_idx;

  cache_fill_ctrl #(.MAX_OUTSTANDING(1)) u_dut_b (
    .clk(clk), .rst_n(rst), .miss_detected(miss_b), .miss_address(maddr_b),
    .fsm_busy(b_busy), .mem_req(b_req), .mem_addr(b_addr),
    .mem_data_valid(b_dv), .mem_data(b_dd),
    .data_we(b_we), .data_word_idx(b_idx), .data_wdata(b_wd), .tag_we(b_tag)
  );

  // ---------------- memory models: fixed-latency pipes ----------------
  logic [LAT_A-1:0] pv_a = '0;
  logic [15:0]      pa_a [LAT_A];
  logic [LAT_B-1:0] pv_b = '0;
  logic [15:0]      pa_b [LAT_B];

  always @(posedge clk) begin
    pv_a <= {pv_a[LAT_A-2:0], a_req};
    pa_a[0] <= a_addr;
    for (int i = 1; i < LAT_A; i++) pa_a[i] <= pa_a[i-1];
    pv_b <= {pv_b[LAT_B-2:0], b_req};
    pa_b[0] <= b_addr;
    for (int i = 1; i < LAT_B; i++) pa_b[i] <= pa_b[i-1];
  end

  assign a_dv = pv_a[LAT_A-1] | inj_a;
  assign a_dd = pa_a[LAT_A-1] ^ 16'h5A5A;
  assign b_dv = pv_b[LAT_B-1];
  assign b_dd = pa_b[LAT_B-1] ^ 16'h5A5A;

  // ---------------- scoreboard ----------------
  logic [15:0] exp_req_a[$];
  logic [19:0] exp_wr_a[$];
  logic [15:0] exp_req_b[$];
  logic [19:0] exp_wr_b[$];
  int total = 0;
  int bad   = 0;
  int wr_seen_a = 0;
  int pend_b = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [2:0] exp_word(input int k, input int mw);
    int off;
    off = CRIT ? mw : 0;
    return 3'((k + off) % 8);
  endfunction

  // Push the full expected request and write sequence of one line fill.
  task automatic push_fill(input int sel, input logic [15:0] addr);
    logic [15:0] base, a;
    logic [2:0]  w;
    int          mw;
    base = {addr[15:4], 4'h0};
    mw   = int'(addr[3:1]);
    for (int k = 0; k < 8; k++) begin
      w = exp_word(k, mw);
      a = base + {12'h0, w, 1'b0};
      if (sel == 0) begin
        exp_req_a.push_back(a);
        exp_wr_a.push_back({(k == 7), w, a ^ 16'h5A5A});
      end else begin
        exp_req_b.push_back(a);
        exp_wr_b.push_back({(k == 7), w, a ^ 16'h5A5A});
      end
    end
  endtask

  // Monitors: pop and compare whenever a DUT presents a request or a write.
  always @(negedge clk) begin
    logic [15:0] ea;
    logic [19:0] ew;
    if (a_req) begin
      if (exp_req_a.size() == 0) chk("a_req_extra", 32'(a_req), 32'd0);
      else begin ea = exp_req_a.pop_front(); chk("a_req_addr", 32'(a_addr), 32'(ea)); end
    end
    if (a_we) begin
      wr_seen_a++;
      if (exp_wr_a.size() == 0) chk("a_we_extra", 32'(a_we), 32'd0);
      else begin ew = exp_wr_a.pop_front(); chk("a_write", 32'({a_tag, a_idx, a_wd}), 32'(ew)); end
    end else if (a_tag) begin
      chk("a_tag_without_we", 32'(a_tag), 32'd0);
    end
  end

  always @(negedge clk) begin
    logic [15:0] ea;
    logic [19:0] ew;
    if (b_req) begin
      chk("b_one_in_flight", 32'(pend_b), 32'd0);
      pend_b++;
      if (exp_req_b.size() == 0) chk("b_req_extra", 32'(b_req), 32'd0);
      else begin ea = exp_req_b.pop_front(); chk("b_req_addr", 32'(b_addr), 32'(ea)); end
    end
    if (b_we) begin
      pend_b--;
      if (exp_wr_b.size() == 0) chk("b_we_extra", 32'(b_we), 32'd0);
      else begin ew = exp_wr_b.pop_front(); chk("b_write", 32'({b_tag, b_idx, b_wd}), 32'(ew)); end
    end else if (b_tag) begin
      chk("b_tag_without_we", 32'(b_tag), 32'd0);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic start_miss(input int sel, input logic [15:0] addr);
    @(posedge clk);
    #1;
    if (sel == 0) begin miss_a = 1'b1; maddr_a = addr; end
    else          begin miss_b = 1'b1; maddr_b = addr; end
  endtask

  // Cycle 0 is the miss cycle; returns the cycle index of tag_we.
  task automatic wait_fill(input int sel, input bit hold, input logic [15:0] next_addr,
                           output int cyc);
    bit found;
    found = 1'b0;
    cyc   = -1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (i == 0) chk("busy_same_cycle", 32'(sel == 0 ? a_busy : b_busy), 32'd1);
      if (i == 1) begin
        if (sel == 0) begin miss_a = hold; maddr_a = next_addr; end
        else          begin miss_b = hold; maddr_b = next_addr; end
      end
      if ((sel == 0 ? a_tag : b_tag) == 1'b1) begin
        cyc   = i;
        found = 1'b1;
        break;
      end
    end
    chk("fill_completes", 32'(found), 32'd1);
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk({tag, "_busy"}, 32'(a_busy), 32'd0);
    chk({tag, "_req"},  32'(a_req),  32'd0);
    chk({tag, "_addr"}, 32'(a_addr), 32'd0);
    chk({tag, "_we"},   32'(a_we),   32'd0);
    chk({tag, "_idx"},  32'(a_idx),  32'd0);
    chk({tag, "_wd"},   32'(a_wd),   32'd0);
    chk({tag, "_tag"},  32'(a_tag),  32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- directed tests ----------------
  initial begin
    int cyc, seen0;

    // Reset held with a miss pending: every output stays 0.
    miss_a  = 1'b1;
    maddr_a = 16'h1236;
    repeat (2) @(posedge clk);
    #1;
    chk_outputs_zero("reset_held");
    chk("reset_b_busy", 32'(b_busy), 32'd0);
    miss_a = 1'b0;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk_outputs_zero("after_release");

    // Pipelined fill, 4 outstanding, latency 4: tag_we on cycle 13.
    push_fill(0, 16'h1236);
    start_miss(0, 16'h1236);
    wait_fill(0, 1'b0, 16'h1236, cyc);
    chk("t1_tag_cycle", 32'(cyc), 32'd13);
    @(negedge clk);
    chk("t1_busy_drop", 32'(a_busy), 32'd0);
    chk("t1_req_q_empty", 32'(exp_req_a.size()), 32'd0);
    chk("t1_wr_q_empty", 32'(exp_wr_a.size()), 32'd0);

    // Spurious response in IDLE.
    @(posedge clk);
    #1 inj_a = 1'b1;
    @(negedge clk);
    chk("idle_spurious_we", 32'(a_we), 32'd0);
    @(posedge clk);
    #1 inj_a = 1'b0;

    // Miss held across completion: refill starts the cycle after tag_we.
    push_fill(0, 16'h1236);
    push_fill(0, 16'h4560);
    start_miss(0, 16'h1236);
    wait_fill(0, 1'b1, 16'h4560, cyc);
    chk("t2_tag_cycle", 32'(cyc), 32'd13);
    @(negedge clk);
    chk("t2_busy_after_tag", 32'(a_busy), 32'd1);
    chk("t2_no_req_in_idle", 32'(a_req), 32'd0);
    @(negedge clk);
    chk("t2_refill_req", 32'(a_req), 32'd1);
    miss_a = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (a_tag) break;
    end
    @(negedge clk);
    chk("t2_busy_drop", 32'(a_busy), 32'd0);
    chk("t2_req_q_empty", 32'(exp_req_a.size()), 32'd0);
    chk("t2_wr_q_empty", 32'(exp_wr_a.size()), 32'd0);

    // Miss inside the line (word 5): ordering depends on the build.
    push_fill(0, 16'h123A);
    start_miss(0, 16'h123A);
    wait_fill(0, 1'b0, 16'h123A, cyc);
    chk("t3_tag_cycle", 32'(cyc), 32'd13);
    @(negedge clk);
    chk("t3_busy_drop", 32'(a_busy), 32'd0);
    chk("t3_wr_q_empty", 32'(exp_wr_a.size()), 32'd0);

    // Serial instance, latency 3: one word every 4 cycles, tag_we on cycle 32.
    push_fill(1, 16'h00F0);
    start_miss(1, 16'h00F0);
    wait_fill(1, 1'b0, 16'h00F0, cyc);
    chk("t4_tag_cycle", 32'(cyc), 32'd32);
    @(negedge clk);
    chk("t4_busy_drop", 32'(b_busy), 32'd0);
    chk("t4_wr_q_empty", 32'(exp_wr_b.size()), 32'd0);

    // Reset after three responses: abort, no tag, late responses ignored.
    push_fill(0, 16'h1236);
    seen0 = wr_seen_a;
    start_miss(0, 16'h1236);
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      #1;
      if (i == 1) miss_a = 1'b0;
      if (wr_seen_a - seen0 >= 3) break;
    end
    chk("t5_three_writes", 32'(wr_seen_a - seen0), 32'd3);
    rst = 1'b1;
    #1;
    chk_outputs_zero("mid_fill_reset");
    exp_req_a.delete();
    exp_wr_a.delete();
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk);
    #1 inj_a = 1'b1;
    @(negedge clk);
    chk("t5_late_pulse_we", 32'(a_we), 32'd0);
    @(posedge clk);
    #1 inj_a = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    chk("t5_no_more_writes", 32'(wr_seen_a - seen0), 32'd3);
    chk("t5_idle_busy", 32'(a_busy), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
